// File: rtl/ram_param.sv
// ram_param: parametrised single-port synchronous RAM on a shared bidirectional
// data bus.
//
// After every reset a hardware clear sweep writes INIT_VALUE to each word, one
// word per cycle. While the sweep runs, busy is high and all accesses are
// ignored. After the sweep, accesses are accepted at the rising clock edge:
//   - Writes use per-byte lane enables.
//   - Reads are registered and raise rd_valid for one cycle.
// The block drives the data bus only while it holds a valid read and the
// master is not writing. At all other times the bus is high-Z.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - asynchronous active-high reset; restarts the clear sweep
//   ena      - access enable
//   wena     - 1 = write, 0 = read (qualified by ena)
//   be       - byte-lane write enables, bit k covers data[8k+7:8k]
//   addr     - word address
//   data     - write data in / read data out, high-Z when not driving
//   busy     - clear sweep in progress
//   rd_valid - read data is being presented this cycle
module ram_param #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    wena,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    inout  wire  [DATA_WIDTH-1:0]   data,
    output logic                    busy,
    output logic                    rd_valid
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int LANES  = DATA_WIDTH / 8;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [ADDR_WIDTH-1:0]   clr_cnt_next;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_data;

    logic                    acc_wr;
    logic                    acc_rd;

    // ------------------------------------------------------------------
    // Clear-sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            INIT: begin
                clr_cnt_next = clr_cnt + 1'b1;
                // The last word is written on the same edge that leaves
                // INIT, so the sweep takes exactly DEPTH cycles.
                if (clr_cnt == {ADDR_WIDTH{1'b1}})
                    state_next = IDLE;
            end
            IDLE: begin
                state_next = IDLE;
            end
            default: begin
                state_next   = INIT;
                clr_cnt_next = '0;
            end
        endcase
    end

    assign busy   = (state == INIT);
    assign acc_wr = (state == IDLE) && ena && wena;
    assign acc_rd = (state == IDLE) && ena && !wena;

    // ------------------------------------------------------------------
    // Storage array. It has no reset; the clear sweep initialises it.
    // While rst is held, the sweep keeps rewriting word 0 with INIT_VALUE.
    // That is harmless.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr_cnt] <= INIT_VALUE;
        end else if (acc_wr) begin
            for (int k = 0; k < LANES; k++) begin
                if (be[k])
                    mem[addr][8*k +: 8] <= data[8*k +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered read path
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= acc_rd;
            if (acc_rd)
                rd_data <= mem[addr];
        end
    end

    // The output enable also depends on the current wena. A master can
    // then start a write in the cycle right after a read without bus
    // contention. Reset clears rd_valid asynchronously, so the bus
    // releases immediately.
    assign data = (rd_valid && !wena) ? rd_data : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_param.sv
module tb_ram_param;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          ena   = 1'b0;
    logic          wena  = 1'b0;
    logic [3:0]    be    = 4'h0;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] wdata = '0;
    logic          drv   = 1'b0;
    logic          busy;
    logic          rd_valid;

    // Pulled-up bus: reads as all ones when nobody drives it.
    tri1  [DW-1:0] data;
    assign data = drv ? wdata : {DW{1'bz}};

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem_m [DEPTH];

    typedef struct {
        logic          ena;
        logic          wena;
        logic [3:0]    be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          exp_vld;
        logic [DW-1:0] exp_bus;
    } vec_t;

    vec_t vecs [13];

    always #5 clk = ~clk;

    ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE('0)) dut (
        .clk(clk), .rst(rst), .ena(ena), .wena(wena), .be(be), .addr(addr),
        .data(data), .busy(busy), .rd_valid(rd_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access cycle: the model predicts the outcome from simple rules.
    // - A read returns the stored word.
    // - A write merges the enabled bytes.
    // - An undriven bus reads as pull-up ones.
    task automatic do_cycle(input logic e, input logic w, input logic [3:0] b,
                            input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output logic v, output logic [DW-1:0] bus);
        logic          exp_v;
        logic [DW-1:0] exp_bus;
        ena = e; wena = w; be = b; addr = a; wdata = d; drv = w;
        exp_v   = e && !w;
        exp_bus = exp_v ? mem_m[a] : (w ? d : {DW{1'b1}});
        if (e && w)
            for (int k = 0; k < DW/8; k++)
                if (b[k]) mem_m[a][8*k +: 8] = d[8*k +: 8];
        @(posedge clk); #1;
        v   = rd_valid;
        bus = data;
        chk("model_rd_valid", 32'(v), 32'(exp_v));
        chk("model_bus", bus, exp_bus);
    endtask

    task automatic wait_clear(input string name);
        int drop = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (!busy) begin
                drop = i;
                break;
            end
        end
        chk(name, 32'(drop), 32'(DEPTH));
    endtask

    initial begin
        logic          v;
        logic [DW-1:0] bus;
        int            drop;

        vecs[0]  = '{1, 0, 4'hf, 5'h00, 32'h0,        1, 32'h00000000};
        vecs[1]  = '{1, 0, 4'hf, 5'h0A, 32'h0,        1, 32'h00000000};
        vecs[2]  = '{1, 0, 4'hf, 5'h1F, 32'h0,        1, 32'h00000000};
        vecs[3]  = '{1, 1, 4'hf, 5'h0A, 32'habcdef12, 0, 32'habcdef12};
        vecs[4]  = '{1, 0, 4'hf, 5'h0A, 32'h0,        1, 32'habcdef12};
        vecs[5]  = '{1, 1, 4'h5, 5'h0A, 32'h12345678, 0, 32'h12345678};
        vecs[6]  = '{1, 0, 4'hf, 5'h0A, 32'h0,        1, 32'hab34ef78};
        vecs[7]  = '{1, 0, 4'hf, 5'h15, 32'h0,        1, 32'h00000000};
        vecs[8]  = '{1, 1, 4'hf, 5'h15, 32'h12345678, 0, 32'h12345678};
        vecs[9]  = '{1, 0, 4'hf, 5'h15, 32'h0,        1, 32'h12345678};
        vecs[10] = '{1, 0, 4'hf, 5'h0A, 32'h0,        1, 32'hab34ef78};
        vecs[11] = '{1, 1, 4'h0, 5'h03, 32'h55aa55aa, 0, 32'h55aa55aa};
        vecs[12] = '{1, 0, 4'hf, 5'h03, 32'h0,        1, 32'h00000000};

        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

        // Reset state, sampled while rst is still high.
        #12;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_bus_z", data, 32'hffffffff);

        // Release rst at t=20, then sweep. Reads at edges 20..27 and writes
        // to word 0 at edges 28..31 must have no effect.
        #8 rst = 1'b0;
        drop = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (!busy) begin
                drop = i;
                break;
            end
            chk("init_rd_valid", 32'(rd_valid), 32'd0);
            if (!drv) chk("init_bus_z", data, 32'hffffffff);
            if (i >= 19 && i <= 26) begin
                ena = 1; wena = 0; drv = 0; addr = 5'h0A;
            end else if (i >= 27 && i <= 30) begin
                ena = 1; wena = 1; drv = 1; be = 4'hf; addr = 5'h00; wdata = 32'hdeadbeef;
            end else begin
                ena = 0; wena = 0; drv = 0;
            end
        end
        chk("init_cycles", 32'(drop), 32'(DEPTH));

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            do_cycle(vecs[i].ena, vecs[i].wena, vecs[i].be, vecs[i].addr, vecs[i].wdata, v, bus);
            chk($sformatf("vec%0d_rd_valid", i), 32'(v), 32'(vecs[i].exp_vld));
            chk($sformatf("vec%0d_bus", i), bus, vecs[i].exp_bus);
        end

        // Ignored accesses with ena low.
        do_cycle(0, 1, 4'hf, 5'h0A, 32'h00000000, v, bus);
        do_cycle(0, 0, 4'hf, 5'h15, 32'h0,        v, bus);
        chk("ign_rd_valid", 32'(v), 32'd0);
        chk("ign_bus_z", bus, 32'hffffffff);
        do_cycle(0, 1, 4'h3, 5'h15, 32'hffffffff, v, bus);
        do_cycle(1, 0, 4'hf, 5'h0A, 32'h0,        v, bus);
        chk("ign_keep_0a", bus, 32'hab34ef78);
        do_cycle(1, 0, 4'hf, 5'h15, 32'h0,        v, bus);
        chk("ign_keep_15", bus, 32'h12345678);

        // Randomised traffic against the model.
        for (int n = 0; n < 300; n++) begin
            do_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
                     AW'($urandom), $urandom, v, bus);
        end

        // Reset in the middle of a read: bus and rd_valid drop before any edge.
        do_cycle(1, 0, 4'hf, 5'h0A, 32'h0, v, bus);
        chk("mid_pre_rd_valid", 32'(v), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rd_valid", 32'(rd_valid), 32'd0);
        chk("mid_bus_z", data, 32'hffffffff);
        chk("mid_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        ena = 0; wena = 0; drv = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        wait_clear("mid_init_cycles");
        do_cycle(1, 0, 4'hf, 5'h0A, 32'h0, v, bus);
        chk("mid_clear_0a", bus, 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
